chdr_pattern_checker: RTL and testbench
=======================================

Name: chdr_pattern_checker

Overview:
- Receive-side counterpart of the null source pattern generator.
- Consumes a CHDR data stream and parses each packet: header, optional timestamp, metadata, payload.
- Verifies each payload line against the incrementing pattern the null source emits. Also checks that the header length field agrees with the packet's beat count and that sequence numbers are contiguous.
- Accumulates line, packet and error counters for register readback. Sits on a block's input data port, or directly on a testbed loopback, as a self-checking sink.

Parameters:
- CHDR_W, 64: CHDR bus width; a power of 2, at least 64.
- ERR_CNT_W, 32: width of each error counter; error counters saturate at their maximum.

Ports:
- rfnoc_chdr_clk, in, 1: the only clock.
- rfnoc_chdr_rst, in, 1: reset, synchronous, active-high.
- clear, in, 1: synchronous clear of all counters and checker state.
- enable, in, 1: when low, beats are accepted and discarded without checking or counting.
- s_chdr_tdata, in, CHDR_W: CHDR input data.
- s_chdr_tlast, in, 1: last beat of packet.
- s_chdr_tvalid, in, 1: input valid.
- s_chdr_tready, out, 1: input ready.
- line_cnt, out, 64: payload lines checked.
- pkt_cnt, out, 64: packets completed.
- data_err_cnt, out, ERR_CNT_W: payload lines that mismatched.
- len_err_cnt, out, ERR_CNT_W: packets whose length was inconsistent.
- seq_err_cnt, out, ERR_CNT_W: sequence-number discontinuities.
- err_pulse, out, 1: high for one cycle after any error is detected.
- first_err_line, out, 64: value of line_cnt at the first data error; valid while data_err_cnt is nonzero.

Behaviour:
- Reset: all counters and first_err_line are 0; err_pulse is 0; s_chdr_tready is 0 during reset and 1 the cycle after. Reset mid-packet abandons the packet, and parsing resumes at ST_HDR.
- Handshake: s_chdr_tready is 1 whenever not in reset; the block never backpressures. A beat is accepted when tvalid and tready are both high.
- Header fields: length is bits [31:16] (bytes, header included); seqnum is [47:32]; num_mdata is [52:48]; pkt_type is [55:53]. A timestamp is present when pkt_type is 3'h7.
- State machine, one transition per accepted beat:
  - ST_HDR: capture the header and set word_cnt to 1. Next state is ST_TS if a timestamp is present and CHDR_W is 64. Otherwise next is ST_MDATA if num_mdata is nonzero, else ST_PYLD. For CHDR_W above 64 the timestamp sits in the header word and no extra beat is consumed.
  - ST_TS: go to ST_MDATA or ST_PYLD as above.
  - ST_MDATA: count down num_mdata beats, then go to ST_PYLD.
  - ST_PYLD: check every beat.
  - Any state: tlast returns the machine to ST_HDR after the end-of-packet checks.
- Payload check: the expected line for running index i (16 bits, wrapping) is {~i, i} replicated CHDR_W/32 times. i starts at 0 after reset or clear and increments per payload line across packet boundaries. On a mismatch, data_err_cnt increments once per line, and first_err_line is latched only on the transition of data_err_cnt from 0. i still advances, so an error does not cascade.
- Length check at tlast: error unless ceil(length*8/CHDR_W) equals the number of beats in the packet. A tlast on the header beat with length above CHDR_W/8 is a length error. A packet with no payload beats is legal if the length matches.
- Sequence check: the first packet after reset or clear loads the expected seqnum. Each later packet must carry the previous seqnum + 1, modulo 2^16; otherwise seq_err_cnt increments. The expected value resyncs to the received value plus 1 in every case.
- Counter timing: counters update on the cycle after the accepting beat (1-cycle latency). line_cnt and pkt_cnt wrap at 2^64. Error counters saturate.
- Multiple errors on one beat (data and length and seq): each counter increments, and err_pulse asserts once.
- clear: takes priority over a beat accepted in the same cycle. That beat is neither checked nor counted, and parsing restarts at ST_HDR, so the remainder of an in-flight packet is treated as a new packet.
- enable low: the parser still tracks packet boundaries, but no checks run and no counters increment. Toggling enable mid-packet takes effect on the next beat.

Decomposition:
- A shared CHDR utility package holds:
  - header field offsets and widths;
  - pkt_type constants;
  - a function that builds a pattern line from index i and CHDR_W. The null source generator also uses this function, so the pattern is defined once.
- A parameterized saturating counter sub-module, chdr_sat_counter, is used for the three error counters.
- The parser FSM and checks stay in the top module.

Test Plan:
- Reset then 50 packets, each a header plus 101 payload lines, length (101+1)*8, seq 0..49, correct pattern -> line_cnt 5050, pkt_cnt 50, all error counters 0, err_pulse never high.
- Same stream with line 7 of packet 3 corrupted -> data_err_cnt 1, first_err_line 310, later lines still pass, line_cnt 5050.
- Packets with seq 0,1,2,5,6 -> seq_err_cnt 1 (at 5); packet 6 passes.
- Header with length 816 but tlast on beat 50 -> len_err_cnt 1, pkt_cnt increments; next packet checks cleanly.
- Packet type 7 with a timestamp and num_mdata 2 at CHDR_W 64 -> the 3 non-payload beats are skipped; pattern continues from the previous index with no data errors.
- clear asserted on a tlast beat mid-stream -> all counters 0 next cycle and that beat is uncounted. The following packet's seqnum is accepted without seq error, and its payload is checked from i=0.

Source files
------------

// File: rtl/chdr_pattern_checker_pkg.sv
// CHDR header layout, packet types and the null-source payload pattern,
// shared by the pattern generator and the pattern checker.
package chdr_pattern_checker_pkg;

   localparam int MAX_CHDR_W     = 512;

   localparam int HDR_LEN_LSB    = 16;
   localparam int HDR_LEN_W      = 16;
   localparam int HDR_SEQ_LSB    = 32;
   localparam int HDR_SEQ_W      = 16;
   localparam int HDR_NMDATA_LSB = 48;
   localparam int HDR_NMDATA_W   = 5;
   localparam int HDR_TYPE_LSB   = 53;
   localparam int HDR_TYPE_W     = 3;

   typedef enum logic [HDR_TYPE_W-1:0] {
      PKT_TYPE_MGMT         = 3'h0,
      PKT_TYPE_STRS         = 3'h1,
      PKT_TYPE_STRC         = 3'h2,
      PKT_TYPE_CTRL         = 3'h4,
      PKT_TYPE_DATA_NO_TS   = 3'h6,
      PKT_TYPE_DATA_WITH_TS = 3'h7
   } pkt_type_t;

   typedef enum logic [1:0] {
      ST_HDR,
      ST_TS,
      ST_MDATA,
      ST_PYLD
   } parse_state_t;

   // Line i is {~i, i} repeated across chdr_w bits; bits above chdr_w are zero.
   function automatic logic [MAX_CHDR_W-1:0] chdr_pattern_line(input logic [15:0] idx,
                                                                input int chdr_w);
      logic [MAX_CHDR_W-1:0] line;
      line = '0;
      for (int k = 0; k < MAX_CHDR_W/32; k++) begin
         if (k < chdr_w/32) line[k*32 +: 32] = {~idx, idx};
      end
      return line;
   endfunction

endpackage

// File: rtl/chdr_pattern_checker_sat_counter.sv
// Error counter that sticks at its maximum value instead of wrapping.
module chdr_sat_counter #(
   parameter int W = 32
) (
   input  logic         rfnoc_chdr_clk,
   input  logic         rfnoc_chdr_rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge rfnoc_chdr_clk) begin
      if (rfnoc_chdr_rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/chdr_pattern_checker.sv
// Self-checking CHDR sink: parses packets, verifies the null-source payload
// pattern, header length and sequence continuity, and keeps readback counters.
//
// state    | meaning
// ST_HDR   | waiting for / consuming the header beat
// ST_TS    | consuming the timestamp beat (64-bit bus only)
// ST_MDATA | skipping metadata beats
// ST_PYLD  | checking payload lines against the pattern
module chdr_pattern_checker
   import chdr_pattern_checker_pkg::*;
#(
   parameter int CHDR_W    = 64,
   parameter int ERR_CNT_W = 32
) (
   input  logic                 rfnoc_chdr_clk,
   input  logic                 rfnoc_chdr_rst,
   input  logic                 clear,
   input  logic                 enable,
   input  logic [CHDR_W-1:0]    s_chdr_tdata,
   input  logic                 s_chdr_tlast,
   input  logic                 s_chdr_tvalid,
   output logic                 s_chdr_tready,
   output logic [63:0]          line_cnt,
   output logic [63:0]          pkt_cnt,
   output logic [ERR_CNT_W-1:0] data_err_cnt,
   output logic [ERR_CNT_W-1:0] len_err_cnt,
   output logic [ERR_CNT_W-1:0] seq_err_cnt,
   output logic                 err_pulse,
   output logic [63:0]          first_err_line
);

   localparam int  BYTES_PER_BEAT = CHDR_W / 8;
   localparam int  BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
   localparam bit  TS_EXTRA_BEAT  = (CHDR_W == 64);

   parse_state_t           state;
   logic                   tready_q;
   logic [15:0]            word_cnt;
   logic [HDR_LEN_W-1:0]   hdr_len;
   logic [HDR_NMDATA_W-1:0] num_mdata;
   logic [HDR_NMDATA_W-1:0] mdata_left;
   logic [15:0]            pat_idx;
   logic [HDR_SEQ_W-1:0]   exp_seq;
   logic                   seq_valid;

   logic                    beat;
   logic                    chk;
   logic [HDR_LEN_W-1:0]    len_in;
   logic [HDR_SEQ_W-1:0]    seq_in;
   logic [HDR_NMDATA_W-1:0] nmdata_in;
   pkt_type_t               type_in;
   logic                    has_ts_beat;
   logic [HDR_LEN_W-1:0]    cur_len;
   logic [16:0]             beats_now;
   logic [16:0]             exp_beats;
   logic [MAX_CHDR_W-1:0]   tdata_ext;
   logic [MAX_CHDR_W-1:0]   exp_line;
   logic                    data_err;
   logic                    len_err;
   logic                    seq_err;

   assign s_chdr_tready = tready_q;
   assign beat          = s_chdr_tvalid & tready_q;
   assign chk           = beat & enable & ~clear;

   assign len_in    = s_chdr_tdata[HDR_LEN_LSB    +: HDR_LEN_W];
   assign seq_in    = s_chdr_tdata[HDR_SEQ_LSB    +: HDR_SEQ_W];
   assign nmdata_in = s_chdr_tdata[HDR_NMDATA_LSB +: HDR_NMDATA_W];
   assign type_in   = pkt_type_t'(s_chdr_tdata[HDR_TYPE_LSB +: HDR_TYPE_W]);

   // Wider buses carry the timestamp inside the header word.
   assign has_ts_beat = (type_in == PKT_TYPE_DATA_WITH_TS) && TS_EXTRA_BEAT;

   always_comb begin
      tdata_ext = '0;
      tdata_ext[CHDR_W-1:0] = s_chdr_tdata;
   end

   assign exp_line = chdr_pattern_line(pat_idx, CHDR_W);

   // A tlast on the header beat must be judged against that header's length.
   assign cur_len   = (state == ST_HDR) ? len_in : hdr_len;
   assign beats_now = (state == ST_HDR) ? 17'd1 : ({1'b0, word_cnt} + 17'd1);
   assign exp_beats = ({1'b0, cur_len} + 17'(BYTES_PER_BEAT - 1)) >> BEAT_SHIFT;

   assign data_err = chk && (state == ST_PYLD) && (tdata_ext != exp_line);
   assign len_err  = chk && s_chdr_tlast && (beats_now != exp_beats);
   assign seq_err  = chk && (state == ST_HDR) && seq_valid && (seq_in != exp_seq);

   always_ff @(posedge rfnoc_chdr_clk) begin
      if (rfnoc_chdr_rst) begin
         tready_q       <= 1'b0;
         state          <= ST_HDR;
         word_cnt       <= '0;
         hdr_len        <= '0;
         num_mdata      <= '0;
         mdata_left     <= '0;
         pat_idx        <= '0;
         exp_seq        <= '0;
         seq_valid      <= 1'b0;
         line_cnt       <= '0;
         pkt_cnt        <= '0;
         first_err_line <= '0;
         err_pulse      <= 1'b0;
      end else begin
         tready_q <= 1'b1;
         if (clear) begin
            state          <= ST_HDR;
            word_cnt       <= '0;
            mdata_left     <= '0;
            pat_idx        <= '0;
            seq_valid      <= 1'b0;
            line_cnt       <= '0;
            pkt_cnt        <= '0;
            first_err_line <= '0;
            err_pulse      <= 1'b0;
         end else begin
            err_pulse <= data_err | len_err | seq_err;
            if (data_err && (data_err_cnt == '0)) begin
               first_err_line <= line_cnt;
            end
            if (beat) begin
               case (state)
                  ST_HDR: begin
                     hdr_len    <= len_in;
                     num_mdata  <= nmdata_in;
                     mdata_left <= nmdata_in;
                     word_cnt   <= 16'd1;
                     if (has_ts_beat) begin
                        state <= ST_TS;
                     end else if (nmdata_in != '0) begin
                        state <= ST_MDATA;
                     end else begin
                        state <= ST_PYLD;
                     end
                     if (enable) begin
                        seq_valid <= 1'b1;
                        exp_seq   <= seq_in + 16'd1;
                     end
                  end
                  ST_TS: begin
                     word_cnt <= (word_cnt == '1) ? word_cnt : word_cnt + 16'd1;
                     state    <= (num_mdata != '0) ? ST_MDATA : ST_PYLD;
                  end
                  ST_MDATA: begin
                     word_cnt   <= (word_cnt == '1) ? word_cnt : word_cnt + 16'd1;
                     mdata_left <= mdata_left - 1'b1;
                     if (mdata_left <= 5'd1) state <= ST_PYLD;
                  end
                  ST_PYLD: begin
                     word_cnt <= (word_cnt == '1) ? word_cnt : word_cnt + 16'd1;
                     if (enable) begin
                        pat_idx  <= pat_idx + 16'd1;
                        line_cnt <= line_cnt + 64'd1;
                     end
                  end
                  default: state <= ST_HDR;
               endcase
               if (s_chdr_tlast) begin
                  state <= ST_HDR;
                  if (enable) pkt_cnt <= pkt_cnt + 64'd1;
               end
            end
         end
      end
   end

   chdr_sat_counter #(.W(ERR_CNT_W)) u_data_err_cnt (
      .rfnoc_chdr_clk (rfnoc_chdr_clk),
      .rfnoc_chdr_rst (rfnoc_chdr_rst),
      .clr            (clear),
      .inc            (data_err),
      .cnt            (data_err_cnt)
   );

   chdr_sat_counter #(.W(ERR_CNT_W)) u_len_err_cnt (
      .rfnoc_chdr_clk (rfnoc_chdr_clk),
      .rfnoc_chdr_rst (rfnoc_chdr_rst),
      .clr            (clear),
      .inc            (len_err),
      .cnt            (len_err_cnt)
   );

   chdr_sat_counter #(.W(ERR_CNT_W)) u_seq_err_cnt (
      .rfnoc_chdr_clk (rfnoc_chdr_clk),
      .rfnoc_chdr_rst (rfnoc_chdr_rst),
      .clr            (clear),
      .inc            (seq_err),
      .cnt            (seq_err_cnt)
   );

endmodule

// File: tb/tb_chdr_pattern_checker.sv
// Directed bench for chdr_pattern_checker at CHDR_W 64.
module tb_chdr_pattern_checker;

   logic        rfnoc_chdr_clk = 1'b0;
   logic        rfnoc_chdr_rst;
   logic        clear;
   logic        enable;
   logic [63:0] s_chdr_tdata;
   logic        s_chdr_tlast;
   logic        s_chdr_tvalid;
   logic        s_chdr_tready;
   logic [63:0] line_cnt;
   logic [63:0] pkt_cnt;
   logic [31:0] data_err_cnt;
   logic [31:0] len_err_cnt;
   logic [31:0] seq_err_cnt;
   logic        err_pulse;
   logic [63:0] first_err_line;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          pulse_cnt = 0;
   logic [15:0] tb_idx;

   always #5 rfnoc_chdr_clk = ~rfnoc_chdr_clk;

   chdr_pattern_checker #(.CHDR_W(64), .ERR_CNT_W(32)) dut (
      .rfnoc_chdr_clk (rfnoc_chdr_clk),
      .rfnoc_chdr_rst (rfnoc_chdr_rst),
      .clear          (clear),
      .enable         (enable),
      .s_chdr_tdata   (s_chdr_tdata),
      .s_chdr_tlast   (s_chdr_tlast),
      .s_chdr_tvalid  (s_chdr_tvalid),
      .s_chdr_tready  (s_chdr_tready),
      .line_cnt       (line_cnt),
      .pkt_cnt        (pkt_cnt),
      .data_err_cnt   (data_err_cnt),
      .len_err_cnt    (len_err_cnt),
      .seq_err_cnt    (seq_err_cnt),
      .err_pulse      (err_pulse),
      .first_err_line (first_err_line)
   );

   always @(negedge rfnoc_chdr_clk) begin
      if (err_pulse === 1'b1) pulse_cnt++;
   end

   function automatic logic [63:0] pat(input logic [15:0] i);
      return {~i, i, ~i, i};
   endfunction

   function automatic logic [63:0] hdr(input logic [15:0] seq, input logic [2:0] ptype,
                                       input logic [4:0] nmd, input logic [15:0] len);
      return {8'h00, ptype, nmd, seq, len, 16'h0000};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge rfnoc_chdr_clk);
         #1;
      end
   endtask

   task automatic drive(input logic [63:0] d, input bit last, input bit clr);
      s_chdr_tdata  = d;
      s_chdr_tlast  = last;
      s_chdr_tvalid = 1'b1;
      clear         = clr;
      @(posedge rfnoc_chdr_clk);
      #1;
      clear         = 1'b0;
      s_chdr_tvalid = 1'b0;
      s_chdr_tlast  = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge rfnoc_chdr_clk);
      #1;
      clear  = 1'b0;
      tb_idx = 16'd0;
   endtask

   // corrupt_a / corrupt_b: payload line numbers to flip a bit in (-1 for none)
   task automatic send_pkt(input logic [15:0] seq, input logic [2:0] ptype, input int nmd,
                           input logic [15:0] len, input int n_pyld,
                           input int corrupt_a, input int corrupt_b, input bit clr_last);
      int total;
      int b;
      logic [63:0] d;
      total = 1 + ((ptype == 3'h7) ? 1 : 0) + nmd + n_pyld;
      b = 1;
      drive(hdr(seq, ptype, 5'(nmd), len), b == total, clr_last && (b == total));
      if (ptype == 3'h7) begin
         b++;
         drive(64'hDEAD_BEEF_0BAD_F00D, b == total, clr_last && (b == total));
      end
      for (int m = 0; m < nmd; m++) begin
         b++;
         drive(64'hA5A5_5A5A_1234_0000 | 64'(m), b == total, clr_last && (b == total));
      end
      for (int p = 0; p < n_pyld; p++) begin
         b++;
         d = pat(tb_idx);
         if (p == corrupt_a || p == corrupt_b) d = d ^ 64'h0000_0100_0000_0000;
         drive(d, b == total, clr_last && (b == total));
         tb_idx = tb_idx + 16'd1;
      end
   endtask

   initial begin
      rfnoc_chdr_rst = 1'b1;
      clear          = 1'b0;
      enable         = 1'b1;
      s_chdr_tdata   = '0;
      s_chdr_tlast   = 1'b0;
      s_chdr_tvalid  = 1'b0;
      tb_idx         = 16'd0;

      // Reset state
      idle(3);
      check("tready_in_reset", 64'(s_chdr_tready), 64'd0);
      check("line_cnt_reset", line_cnt, 64'd0);
      check("pkt_cnt_reset", pkt_cnt, 64'd0);
      check("data_err_reset", 64'(data_err_cnt), 64'd0);
      check("first_err_reset", first_err_line, 64'd0);
      check("err_pulse_reset", 64'(err_pulse), 64'd0);
      rfnoc_chdr_rst = 1'b0;
      idle(1);
      check("tready_after_reset", 64'(s_chdr_tready), 64'd1);

      // Clean stream: 50 packets x 101 lines
      send_pkt(16'd0, 3'h6, 0, 16'd816, 101, -1, -1, 1'b0);
      check("line_cnt_pkt0", line_cnt, 64'd101);
      check("pkt_cnt_pkt0", pkt_cnt, 64'd1);
      for (int s = 1; s < 50; s++) send_pkt(16'(s), 3'h6, 0, 16'd816, 101, -1, -1, 1'b0);
      idle(1);
      check("clean_line_cnt", line_cnt, 64'd5050);
      check("clean_pkt_cnt", pkt_cnt, 64'd50);
      check("clean_data_err", 64'(data_err_cnt), 64'd0);
      check("clean_len_err", 64'(len_err_cnt), 64'd0);
      check("clean_seq_err", 64'(seq_err_cnt), 64'd0);
      check("clean_pulses", 64'(pulse_cnt), 64'd0);

      // Same stream with pkt 3 line 7 and pkt 10 line 0 corrupted
      do_clear();
      check("clear_line_cnt", line_cnt, 64'd0);
      for (int s = 0; s < 50; s++)
         send_pkt(16'(s), 3'h6, 0, 16'd816, 101, (s == 3) ? 7 : -1, (s == 10) ? 0 : -1, 1'b0);
      idle(1);
      check("corrupt_data_err", 64'(data_err_cnt), 64'd2);
      check("corrupt_first_err", first_err_line, 64'd310);
      check("corrupt_line_cnt", line_cnt, 64'd5050);
      check("corrupt_seq_err", 64'(seq_err_cnt), 64'd0);
      check("corrupt_pulses", 64'(pulse_cnt), 64'd2);

      // Sequence gap 2 -> 5
      do_clear();
      send_pkt(16'd0, 3'h6, 0, 16'd40, 4, -1, -1, 1'b0);
      send_pkt(16'd1, 3'h6, 0, 16'd40, 4, -1, -1, 1'b0);
      send_pkt(16'd2, 3'h6, 0, 16'd40, 4, -1, -1, 1'b0);
      check("seq_before_gap", 64'(seq_err_cnt), 64'd0);
      send_pkt(16'd5, 3'h6, 0, 16'd40, 4, -1, -1, 1'b0);
      check("seq_at_gap", 64'(seq_err_cnt), 64'd1);
      send_pkt(16'd6, 3'h6, 0, 16'd40, 4, -1, -1, 1'b0);
      idle(1);
      check("seq_after_resync", 64'(seq_err_cnt), 64'd1);
      check("seq_line_cnt", line_cnt, 64'd20);
      check("seq_pkt_cnt", pkt_cnt, 64'd5);
      check("seq_data_err", 64'(data_err_cnt), 64'd0);
      check("seq_pulses", 64'(pulse_cnt), 64'd3);

      // Length 816 with tlast on beat 50, then a clean packet
      send_pkt(16'd7, 3'h6, 0, 16'd816, 49, -1, -1, 1'b0);
      check("len_short_err", 64'(len_err_cnt), 64'd1);
      check("len_short_pkt", pkt_cnt, 64'd6);
      send_pkt(16'd8, 3'h6, 0, 16'd40, 4, -1, -1, 1'b0);
      check("len_next_clean", 64'(len_err_cnt), 64'd1);
      check("len_next_data", 64'(data_err_cnt), 64'd0);
      check("len_line_cnt", line_cnt, 64'd73);
      // tlast on header with length 16 is an error; header-only length 8 is legal
      send_pkt(16'd9, 3'h6, 0, 16'd16, 0, -1, -1, 1'b0);
      check("hdr_only_long", 64'(len_err_cnt), 64'd2);
      send_pkt(16'd10, 3'h6, 0, 16'd8, 0, -1, -1, 1'b0);
      idle(1);
      check("hdr_only_ok", 64'(len_err_cnt), 64'd2);
      check("hdr_only_pkt", pkt_cnt, 64'd9);
      check("len_pulses", 64'(pulse_cnt), 64'd5);

      // Timestamp plus two metadata beats are skipped
      send_pkt(16'd11, 3'h7, 2, 16'd64, 4, -1, -1, 1'b0);
      check("ts_md_line_cnt", line_cnt, 64'd77);
      check("ts_md_data_err", 64'(data_err_cnt), 64'd0);
      check("ts_md_len_err", 64'(len_err_cnt), 64'd2);
      check("ts_md_seq_err", 64'(seq_err_cnt), 64'd1);

      // Clear on the tlast beat
      send_pkt(16'd12, 3'h6, 0, 16'd40, 4, -1, -1, 1'b1);
      tb_idx = 16'd0;
      check("clr_line_cnt", line_cnt, 64'd0);
      check("clr_pkt_cnt", pkt_cnt, 64'd0);
      check("clr_len_err", 64'(len_err_cnt), 64'd0);
      check("clr_seq_err", 64'(seq_err_cnt), 64'd0);
      check("clr_err_pulse", 64'(err_pulse), 64'd0);
      send_pkt(16'd100, 3'h6, 0, 16'd40, 4, -1, -1, 1'b0);
      idle(1);
      check("post_clr_seq", 64'(seq_err_cnt), 64'd0);
      check("post_clr_data", 64'(data_err_cnt), 64'd0);
      check("post_clr_line", line_cnt, 64'd4);
      check("post_clr_pkt", pkt_cnt, 64'd1);
      check("post_clr_pulses", 64'(pulse_cnt), 64'd5);

      // Disabled: a broken packet is not checked or counted
      enable = 1'b0;
      send_pkt(16'd999, 3'h6, 0, 16'd8, 4, 1, -1, 1'b0);
      idle(1);
      check("dis_line_cnt", line_cnt, 64'd4);
      check("dis_pkt_cnt", pkt_cnt, 64'd1);
      check("dis_errs", 64'(data_err_cnt) + 64'(len_err_cnt) + 64'(seq_err_cnt), 64'd0);
      check("dis_pulses", 64'(pulse_cnt), 64'd5);
      enable = 1'b1;

      // Reset mid-packet, then a fresh packet from index 0
      drive(hdr(16'd200, 3'h6, 5'd0, 16'd40), 1'b0, 1'b0);
      drive(pat(16'd0), 1'b0, 1'b0);
      drive(pat(16'd1), 1'b0, 1'b0);
      rfnoc_chdr_rst = 1'b1;
      idle(2);
      check("rst_mid_tready", 64'(s_chdr_tready), 64'd0);
      check("rst_mid_line", line_cnt, 64'd0);
      rfnoc_chdr_rst = 1'b0;
      tb_idx = 16'd0;
      idle(1);
      send_pkt(16'd300, 3'h6, 0, 16'd40, 4, -1, -1, 1'b0);
      check("rst_resume_line", line_cnt, 64'd4);
      check("rst_resume_pkt", pkt_cnt, 64'd1);
      check("rst_resume_errs", 64'(data_err_cnt) + 64'(len_err_cnt) + 64'(seq_err_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
